feedback_rx: RTL and testbench
==============================

FEEDBACK_RX -- requirements
Module: feedback_rx

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, bit width of every data/address word.
REQ-002 SHALL have parameter TABLE_ENTRIES, default 128, number of per-node table slots.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 nreset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; high in IDLE begins packet reception.
REQ-006 in_valid  input  1  in_data carries the next feedback word this cycle.
REQ-007 in_data  input  WORD_WIDTH  feedback word stream: fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID, in that order.
REQ-008 MY_NODE_ID  input  WORD_WIDTH  this node's ID.
REQ-009 MY_CLUSTER_ID  input  WORD_WIDTH  this node's cluster ID.
REQ-010 address  output  WORD_WIDTH  memory byte address for writes.
REQ-011 wr_en  output  1  memory write strobe, one cycle per word written.
REQ-012 data_out  output  WORD_WIDTH  memory write data.
REQ-013 done  output  1  one-cycle pulse, packet accepted and committed.
REQ-014 drop  output  1  one-cycle pulse, packet rejected, no writes issued.

Function
REQ-015 States SHALL be IDLE, SRC, BATT, VAL, CLUS, DEST, CHECK, WR_BATT, WR_VAL, DONE, DROP.
REQ-016 IDLE -> SRC SHALL occur on a clock edge with start=1; otherwise IDLE holds.
REQ-017 SRC, BATT, VAL, CLUS, DEST SHALL each capture in_data into its own register and advance only on a cycle with in_valid=1; in_valid=0 holds state (gaps of any length allowed).
REQ-018 in_valid outside SRC..DEST SHALL be ignored.
REQ-019 CHECK SHALL go to WR_BATT when all accept conditions hold, else DROP.
REQ-020 Accept conditions: fdestinationID == MY_NODE_ID or 16'hFFFF (broadcast); fsourceID < TABLE_ENTRIES; fsourceID != MY_NODE_ID.
REQ-021 WR_BATT SHALL drive wr_en=1, address = 16'h0148 + fsourceID*2, data_out = fbatteryStat.
REQ-022 WR_VAL SHALL drive wr_en=1, address = 16'h0048 + fsourceID*2, data_out = fValue.
REQ-023 Address arithmetic SHALL be WORD_WIDTH-bit, truncated (wraps modulo 2^WORD_WIDTH).
REQ-024 DONE SHALL assert done for exactly one cycle then go to IDLE; DROP SHALL likewise assert drop then go to IDLE.
REQ-025 Latency: done SHALL pulse 4 cycles after the edge capturing fdestinationID (CHECK, WR_BATT, WR_VAL, DONE).
REQ-026 Outside WR_BATT/WR_VAL, wr_en SHALL be 0, address and data_out SHALL be 0.
REQ-027 start while not in IDLE SHALL be ignored; start held high through DONE/DROP SHALL begin a new packet the cycle after returning to IDLE.
REQ-028 done and drop SHALL never be high together.

Reset
REQ-029 nreset=0 SHALL immediately force IDLE, clear all captured fields, wr_en=0, address=0, data_out=0, done=0, drop=0, including mid-packet and mid-write.
REQ-030 After reset release, the first packet SHALL require a fresh start in IDLE; partial words before reset SHALL be discarded.

Configuration
REQ-031 Macro FEEDBACK_CLUSTER_FILTER_EN defined: accept conditions additionally require fclusterID == MY_CLUSTER_ID; mismatch -> DROP.
REQ-032 Macro undefined: fclusterID captured but unused; packets from any cluster accepted.

Structure
REQ-033 Shared package SHALL hold Q-table base 16'h0048, battery-table base 16'h0148, broadcast ID 16'hFFFF, and the state encoding enum.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 MY_NODE_ID=3, start, words 5,0x0064,0x0200,1,3 back-to-back -> writes (0x0152,0x0064) then (0x0052,0x0200), done pulse 4 cycles after last word.
REQ-036 Same packet with fdestinationID=0xFFFF and in_valid gaps of 2 cycles between words -> identical writes, done.
REQ-037 fdestinationID=7 (not mine), or fsourceID=200, or fsourceID=3 -> drop pulse, wr_en never asserted.
REQ-038 MY_CLUSTER_ID=1, fclusterID=2 -> with FEEDBACK_CLUSTER_FILTER_EN drop; without it writes and done.
REQ-039 nreset low during WR_BATT -> wr_en falls immediately, no WR_VAL write, IDLE after release; next packet processed normally.
REQ-040 start held high for two packets -> second SRC capture starts the cycle after the first done.

Source files
------------

// File: rtl/feedback_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : feedback_rx_pkg
//  Purpose  : Shared constants and state encoding for the feedback packet
//             receiver (table base addresses, broadcast ID, FSM states).
//  Revision : 1.0  initial release
// ============================================================================
package feedback_rx_pkg;

    // Base byte address of the per-node Q-value table
    localparam logic [15:0] Q_TABLE_BASE    = 16'h0048;
    // Base byte address of the per-node battery-status table
    localparam logic [15:0] BATT_TABLE_BASE = 16'h0148;
    // Destination ID that every node accepts
    localparam logic [15:0] BROADCAST_ID    = 16'hFFFF;

    // Receiver state encoding
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SRC     = 4'd1,
        ST_BATT    = 4'd2,
        ST_VAL     = 4'd3,
        ST_CLUS    = 4'd4,
        ST_DEST    = 4'd5,
        ST_CHECK   = 4'd6,
        ST_WR_BATT = 4'd7,
        ST_WR_VAL  = 4'd8,
        ST_DONE    = 4'd9,
        ST_DROP    = 4'd10
    } state_t;

endpackage : feedback_rx_pkg
`default_nettype wire

// File: rtl/feedback_rx.sv
`default_nettype none
// ============================================================================
//  Module   : feedback_rx
//  Purpose  : Receives a five-word feedback packet (source, battery, value,
//             cluster, destination), filters it against this node's identity
//             and commits battery and value words into per-source tables.
//  Options  : FEEDBACK_CLUSTER_FILTER_EN - when defined, packets whose cluster
//             ID differs from MY_CLUSTER_ID are dropped.
//  Revision : 1.0  initial release
// ============================================================================
module feedback_rx
    import feedback_rx_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int TABLE_ENTRIES = 128
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    output logic [WORD_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  drop
);

    // One extra bit so a table size equal to 2^WORD_WIDTH still compares correctly
    localparam logic [WORD_WIDTH:0] TABLE_LIMIT = (WORD_WIDTH+1)'(TABLE_ENTRIES);

    state_t                state;

    // Captured packet fields
    logic [WORD_WIDTH-1:0] src_id;
    logic [WORD_WIDTH-1:0] batt_stat;
    logic [WORD_WIDTH-1:0] fb_value;
    logic [WORD_WIDTH-1:0] cluster_id;
    logic [WORD_WIDTH-1:0] dest_id;

    // Derived decision terms
    logic                  dest_ok;
    logic                  src_in_range;
    logic                  src_not_self;
    logic                  cluster_ok;
    logic                  accept;
    logic [WORD_WIDTH-1:0] src_x2;
    logic [WORD_WIDTH-1:0] batt_addr;
    logic [WORD_WIDTH-1:0] val_addr;

    // Tables hold 16-bit entries, so each source occupies two bytes
    assign src_x2    = {src_id[WORD_WIDTH-2:0], 1'b0};
    // Address sums deliberately wrap at WORD_WIDTH bits
    assign batt_addr = WORD_WIDTH'(BATT_TABLE_BASE) + src_x2;
    assign val_addr  = WORD_WIDTH'(Q_TABLE_BASE)    + src_x2;

    assign dest_ok      = (dest_id == MY_NODE_ID) || (dest_id == WORD_WIDTH'(BROADCAST_ID));
    assign src_in_range = ({1'b0, src_id} < TABLE_LIMIT);
    // A node never records feedback about itself
    assign src_not_self = (src_id != MY_NODE_ID);

`ifdef FEEDBACK_CLUSTER_FILTER_EN
    assign cluster_ok = (cluster_id == MY_CLUSTER_ID);
`else
    // Cluster ID is still captured so the word stream stays aligned, but unused
    assign cluster_ok = 1'b1;
    logic unused_cluster;
    assign unused_cluster = &{1'b0, cluster_id, MY_CLUSTER_ID};
`endif

    assign accept = dest_ok && src_in_range && src_not_self && cluster_ok;

    // Packet FSM; outputs are registered so they line up with the state they belong to
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            src_id     <= '0;
            batt_stat  <= '0;
            fb_value   <= '0;
            cluster_id <= '0;
            dest_id    <= '0;
            wr_en      <= 1'b0;
            address    <= '0;
            data_out   <= '0;
            done       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            // Outputs idle unless the next state drives them
            wr_en    <= 1'b0;
            address  <= '0;
            data_out <= '0;
            done     <= 1'b0;
            drop     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SRC;
                    end
                end

                ST_SRC: begin
                    if (in_valid) begin
                        src_id <= in_data;
                        state  <= ST_BATT;
                    end
                end

                ST_BATT: begin
                    if (in_valid) begin
                        batt_stat <= in_data;
                        state     <= ST_VAL;
                    end
                end

                ST_VAL: begin
                    if (in_valid) begin
                        fb_value <= in_data;
                        state    <= ST_CLUS;
                    end
                end

                ST_CLUS: begin
                    if (in_valid) begin
                        cluster_id <= in_data;
                        state      <= ST_DEST;
                    end
                end

                ST_DEST: begin
                    if (in_valid) begin
                        dest_id <= in_data;
                        state   <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (accept) begin
                        state    <= ST_WR_BATT;
                        wr_en    <= 1'b1;
                        address  <= batt_addr;
                        data_out <= batt_stat;
                    end else begin
                        state <= ST_DROP;
                        drop  <= 1'b1;
                    end
                end

                ST_WR_BATT: begin
                    state    <= ST_WR_VAL;
                    wr_en    <= 1'b1;
                    address  <= val_addr;
                    data_out <= fb_value;
                end

                ST_WR_VAL: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                ST_DROP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : feedback_rx
`default_nettype wire

// File: tb/tb_feedback_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feedback_rx
//  Purpose  : Self-checking bench for feedback_rx: directed vector table,
//             multi-cycle corner sequences and randomized packets compared
//             against a behavioural acceptance/address model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_feedback_rx;

    logic        clock;
    logic        nreset;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] my_node;
    logic [15:0] my_cluster;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        done;
    logic        drop;

    int tests;
    int fails;
    int stray;

    feedback_rx #(
        .WORD_WIDTH   (16),
        .TABLE_ENTRIES(128)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .MY_NODE_ID   (my_node),
        .MY_CLUSTER_ID(my_cluster),
        .address      (address),
        .wr_en        (wr_en),
        .data_out     (data_out),
        .done         (done),
        .drop         (drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] src, batt, val, clus, dest, node, mycl;
        int          gap;
        bit          ok;
        logic [15:0] a0, d0, a1, d1;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
        if (done && drop) stray++;
    endtask

    // Present five words with 'gap' idle cycles before each; start may toggle meanwhile
    task automatic feed(input logic [15:0] w[5], input int gap, input bit keep_start);
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                if (!keep_start) start = 1'($urandom_range(0, 1));
                tick();
                if (wr_en || done || drop) stray++;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            if (!keep_start) start = 1'($urandom_range(0, 1));
            tick();
            if (wr_en || done || drop) stray++;
        end
        in_valid = 1'b0;
        if (!keep_start) start = 1'b0;
    endtask

    // Observe up to 8 cycles after the destination word; k counts edges after that capture
    task automatic collect(output int nwr, output logic [15:0] ga[2], output logic [15:0] gd[2],
                           output int dk, output int pk);
        nwr = 0; dk = -1; pk = -1;
        ga[0] = '0; ga[1] = '0; gd[0] = '0; gd[1] = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (wr_en) begin
                if (nwr < 2) begin
                    ga[nwr] = address;
                    gd[nwr] = data_out;
                end
                nwr++;
            end else if (address != 16'h0 || data_out != 16'h0) begin
                stray++;
            end
            if (done && dk < 0) dk = k;
            if (drop && pk < 0) pk = k;
            if (dk >= 0 || pk >= 0) break;
        end
    endtask

    task automatic check_result(input string nm, input bit ok,
                                input logic [15:0] a0, input logic [15:0] d0,
                                input logic [15:0] a1, input logic [15:0] d1,
                                input int nwr, input logic [15:0] ga[2], input logic [15:0] gd[2],
                                input int dk, input int pk);
        if (ok) begin
            // done is visible in the fourth cycle after the capture edge
            chk({nm, " done_lat"}, dk, 3);
            chk({nm, " drop"}, pk, -1);
            chk({nm, " n_writes"}, nwr, 2);
            chk({nm, " batt_addr"}, ga[0], a0);
            chk({nm, " batt_data"}, gd[0], d0);
            chk({nm, " val_addr"}, ga[1], a1);
            chk({nm, " val_data"}, gd[1], d1);
        end else begin
            chk({nm, " drop_lat"}, pk, 1);
            chk({nm, " done"}, dk, -1);
            chk({nm, " n_writes"}, nwr, 0);
        end
        chk({nm, " stray"}, stray, 0);
    endtask

    task automatic run_and_check(input string nm, input logic [15:0] w[5], input int gap,
                                 input bit ok, input logic [15:0] a0, input logic [15:0] d0,
                                 input logic [15:0] a1, input logic [15:0] d1);
        int          nwr, dk, pk;
        logic [15:0] ga[2];
        logic [15:0] gd[2];
        start = 1'b0; in_valid = 1'b0;
        tick(); tick();
        stray = 0;
        start = 1'b1;
        tick();
        feed(w, gap, 1'b0);
        collect(nwr, ga, gd, dk, pk);
        check_result(nm, ok, a0, d0, a1, d1, nwr, ga, gd, dk, pk);
    endtask

    // Reference acceptance rule
    function automatic bit model_ok(int src, int dest, int clus, int node, int mycl);
        bit ok;
        bit filter;
`ifdef FEEDBACK_CLUSTER_FILTER_EN
        filter = 1'b1;
`else
        filter = 1'b0;
`endif
        ok = ((dest == node) || (dest == 65535)) && (src < 128) && (src != node)
             && (!filter || (clus == mycl));
        return ok;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[5];
        int          nwr, dk, pk;
        logic [15:0] ga[2];
        logic [15:0] gd[2];

        tests = 0; fails = 0; stray = 0;
        start = 1'b0; in_valid = 1'b0; in_data = '0;
        my_node = 16'd3; my_cluster = 16'd1;

        // Directed vectors
        vecs[0] = '{16'd5,   16'h0064, 16'h0200, 16'd1, 16'd3,      16'd3,    16'd1, 0, 1'b1, 16'h0152, 16'h0064, 16'h0052, 16'h0200};
        vecs[1] = '{16'd5,   16'h0064, 16'h0200, 16'd1, 16'hFFFF,   16'd3,    16'd1, 2, 1'b1, 16'h0152, 16'h0064, 16'h0052, 16'h0200};
        vecs[2] = '{16'd5,   16'h0064, 16'h0200, 16'd1, 16'd7,      16'd3,    16'd1, 0, 1'b0, 16'h0,    16'h0,    16'h0,    16'h0};
        vecs[3] = '{16'd200, 16'h0064, 16'h0200, 16'd1, 16'd3,      16'd3,    16'd1, 0, 1'b0, 16'h0,    16'h0,    16'h0,    16'h0};
        vecs[4] = '{16'd3,   16'h0064, 16'h0200, 16'd1, 16'd3,      16'd3,    16'd1, 1, 1'b0, 16'h0,    16'h0,    16'h0,    16'h0};
`ifdef FEEDBACK_CLUSTER_FILTER_EN
        vecs[5] = '{16'd5,   16'h0064, 16'h0200, 16'd2, 16'd3,      16'd3,    16'd1, 0, 1'b0, 16'h0,    16'h0,    16'h0,    16'h0};
`else
        vecs[5] = '{16'd5,   16'h0064, 16'h0200, 16'd2, 16'd3,      16'd3,    16'd1, 0, 1'b1, 16'h0152, 16'h0064, 16'h0052, 16'h0200};
`endif
        vecs[6] = '{16'd127, 16'hABCD, 16'h1234, 16'd1, 16'hFFFF,   16'd3,    16'd1, 0, 1'b1, 16'h0246, 16'hABCD, 16'h0146, 16'h1234};
        vecs[7] = '{16'd128, 16'hABCD, 16'h1234, 16'd1, 16'hFFFF,   16'd3,    16'd1, 0, 1'b0, 16'h0,    16'h0,    16'h0,    16'h0};
        vecs[8] = '{16'd0,   16'h5A5A, 16'hC3C3, 16'd1, 16'h0010,   16'h0010, 16'd1, 1, 1'b1, 16'h0148, 16'h5A5A, 16'h0048, 16'hC3C3};

        // Reset state, with start and in_valid asserted during reset
        nreset = 1'b0; start = 1'b1; in_valid = 1'b1;
        tick(); tick();
        chk("reset wr_en", wr_en, 0);
        chk("reset address", address, 0);
        chk("reset data_out", data_out, 0);
        chk("reset done", done, 0);
        chk("reset drop", drop, 0);
        start = 1'b0; in_valid = 1'b0;
        nreset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            my_node = vecs[i].node; my_cluster = vecs[i].mycl;
            w = '{vecs[i].src, vecs[i].batt, vecs[i].val, vecs[i].clus, vecs[i].dest};
            run_and_check($sformatf("vec%0d", i), w, vecs[i].gap, vecs[i].ok,
                          vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
        end

        // Reset asserted during the battery write
        my_node = 16'd3; my_cluster = 16'd1;
        w = '{16'd5, 16'h0064, 16'h0200, 16'd1, 16'd3};
        start = 1'b0; tick(); tick(); stray = 0;
        start = 1'b1; tick(); start = 1'b0;
        feed(w, 0, 1'b1);
        tick();
        chk("rstwr wr_en_before", wr_en, 1);
        chk("rstwr addr_before", address, 16'h0152);
        nreset = 1'b0;
        #1;
        chk("rstwr wr_en_async", wr_en, 0);
        chk("rstwr addr_async", address, 0);
        chk("rstwr data_async", data_out, 0);
        tick();
        nreset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (wr_en || done || drop) stray++;
        end
        chk("rstwr quiet_after", stray, 0);
        run_and_check("rstwr next", w, 0, 1'b1, 16'h0152, 16'h0064, 16'h0052, 16'h0200);

        // Partial packet cut by reset; words without a fresh start must be ignored
        start = 1'b0; tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'd5; tick();
        in_data = 16'h0064; tick();
        in_valid = 1'b0;
        nreset = 1'b0; tick(); nreset = 1'b1; tick();
        stray = 0;
        feed(w, 0, 1'b1);
        collect(nwr, ga, gd, dk, pk);
        chk("nostart n_writes", nwr, 0);
        chk("nostart done", dk, -1);
        chk("nostart drop", pk, -1);
        chk("nostart stray", stray, 0);

        // Start held high across two packets
        start = 1'b0; tick(); tick(); stray = 0;
        start = 1'b1; tick();
        feed(w, 0, 1'b1);
        collect(nwr, ga, gd, dk, pk);
        check_result("hold pkt1", 1'b1, 16'h0152, 16'h0064, 16'h0052, 16'h0200, nwr, ga, gd, dk, pk);
        tick();                         // DONE -> IDLE
        in_valid = 1'b1; in_data = 16'd200;
        tick();                         // IDLE -> SRC, this word must be ignored
        w = '{16'd6, 16'h0011, 16'h0022, 16'd0, 16'd3};
        feed(w, 0, 1'b1);
        start = 1'b0;
        collect(nwr, ga, gd, dk, pk);
        check_result("hold pkt2", 1'b1, 16'h0154, 16'h0011, 16'h0054, 16'h0022, nwr, ga, gd, dk, pk);

        // Randomized packets against the model
        for (int n = 0; n < 40; n++) begin
            int node, mycl, src, dest, clus, gap;
            bit ok;
            node = $urandom_range(0, 15);
            mycl = $urandom_range(0, 3);
            clus = $urandom_range(0, 3);
            gap  = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0, 1:    src = $urandom_range(0, 127);
                2:       src = $urandom_range(0, 255);
                default: begin
                    case ($urandom_range(0, 2))
                        0:       src = node;
                        1:       src = 127;
                        default: src = 128;
                    endcase
                end
            endcase
            case ($urandom_range(0, 3))
                0, 1:    dest = node;
                2:       dest = 65535;
                default: dest = $urandom_range(0, 65535);
            endcase
            ok = model_ok(src, dest, clus, node, mycl);
            my_node = 16'(node); my_cluster = 16'(mycl);
            w = '{16'(src), 16'($urandom), 16'($urandom), 16'(clus), 16'(dest)};
            run_and_check($sformatf("rnd%0d", n), w, gap, ok,
                          16'((328 + 2 * src) % 65536), w[1],
                          16'((72 + 2 * src) % 65536), w[2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_feedback_rx
`default_nettype wire
